reset_gen: RTL
==============

# reset_gen

Reset request generator sitting upstream of the chip's reset synchronizer. It drives the raw active-low system reset line from three sources: power-on, a software request, and an internal watchdog timeout. Each reset event produces a low pulse of guaranteed minimum width, followed by a cooldown window. The block records which source caused the most recent reset so firmware can read it after restart.

## Interface
- HOLD_CYCLES, 16: cycles `sys_rst_n` is held low per reset event (≥2).
- COOL_CYCLES, 8: cycles after release during which new requests are ignored (≥1).
- WDOG_TIMEOUT, 1_000_000: watchdog period in cycles (≥2).
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low; power-on reset from a domain independent of `sys_rst_n`, never fed by `sys_rst_n`.
- sw_rst_req  input  1  software reset request, level; acted on at its rising edge.
- wdog_en  input  1  watchdog enable, level.
- wdog_kick  input  1  watchdog service pulse; clears the watchdog count.
- cause_clr  input  1  clears `rst_cause` to 2'b00; honoured only in IDLE.
- sys_rst_n  output  1  registered raw reset line to the downstream synchronizer; low = reset.
- rst_cause  output  2  bit0 = software, bit1 = watchdog; 2'b00 = power-on.
- busy  output  1  high in ASSERT or COOL.

## Operation
- FSM states: ASSERT, COOL, IDLE.
- Async reset (`rst_n` low):
  - state = ASSERT, hold counter = 0, watchdog count = 0, `sw_rst_req` edge-detect register = 1 (a request held high through power-on does not retrigger).
  - Outputs: `sys_rst_n` = 0, `rst_cause` = 2'b00, `busy` = 1.
- ASSERT: `sys_rst_n` = 0; hold counter increments each cycle. When counter = HOLD_CYCLES-1, clear counter and go to COOL.
- COOL: `sys_rst_n` = 1. Software edges and watchdog are ignored, and the edge register still tracks `sw_rst_req`. Counter increments; at COOL_CYCLES-1, clear counter and go to IDLE.
- IDLE: `sys_rst_n` = 1.
  - Watchdog count increments when `wdog_en`=1 and `wdog_kick`=0.
  - `wdog_kick`=1 or `wdog_en`=0 forces the count to 0.
- Trigger in IDLE: sw rising edge (`sw_rst_req`=1 and edge register = 0), or watchdog count = WDOG_TIMEOUT-1 with `wdog_en`=1 and `wdog_kick`=0.
- On trigger:
  - go to ASSERT and clear the watchdog count.
  - `rst_cause` is overwritten: bit0 = sw trigger, bit1 = watchdog trigger. Both set when both fire in the same cycle.
- `cause_clr` in IDLE with no trigger that cycle: `rst_cause` = 0. A trigger in the same cycle wins over `cause_clr`.
- Widths:
  - hold counter is $clog2(max(HOLD_CYCLES, COOL_CYCLES)) bits.
  - watchdog counter is $clog2(WDOG_TIMEOUT) bits.
  - No counter wraps; it is compared, then cleared.

## Timing
- Trigger sampled at edge N gives `sys_rst_n` = 0 from edge N (registered output, visible after edge N).
- Low pulse is exactly HOLD_CYCLES cycles; the release edge is N+HOLD_CYCLES.
- Requests are accepted again from edge N+HOLD_CYCLES+COOL_CYCLES.
- After `rst_n` deassertion, `sys_rst_n` rises HOLD_CYCLES rising edges later.
- Watchdog: enabled and never kicked from IDLE entry, the trigger occurs WDOG_TIMEOUT cycles after entry.
- `busy` is combinational from state. All other outputs are registered.
- `rst_n` low mid-operation, in any state: immediate return to the reset values, including `rst_cause` = 0.

## Structure
- Shared package `reset_pkg`:
  - state enum `rst_state_t` {ASSERT, COOL, IDLE}.
  - cause constants CAUSE_POR=2'b00, CAUSE_SW=2'b01, CAUSE_WDOG=2'b10.
- Sub-module `wdog_timer`: holds the watchdog counter. Inputs en, kick, clr. Output `timeout`, high for one cycle at count WDOG_TIMEOUT-1.
- FSM, hold counter, edge detect and cause register live in `reset_gen`.

## Test plan
- Power-on: deassert `rst_n` with HOLD_CYCLES=16 -> `sys_rst_n` low for 16 edges then high; `rst_cause`=00; `busy` drops 8 cycles after release.
- Software reset: in IDLE, raise `sw_rst_req` and hold it high 100 cycles -> one 16-cycle low pulse, `rst_cause`=01, no second pulse; a second rising edge in COOL is ignored.
- Watchdog: WDOG_TIMEOUT=50, `wdog_en`=1, no kicks -> trigger 50 cycles after IDLE entry, `rst_cause`=10. Kicking every 40 cycles -> no reset for 1000 cycles.
- Simultaneous: sw edge in the same cycle as watchdog timeout -> single pulse, `rst_cause`=11. `cause_clr` in the same cycle does not clear.
- Mid-operation reset: drop `rst_n` at cycle 5 of ASSERT, release 3 cycles later -> full 16-cycle pulse restarts and `rst_cause`=00.
- `cause_clr` in IDLE after a watchdog reset -> `rst_cause`=00 next cycle. `cause_clr` in COOL -> no effect.

Source files
------------

// File: rtl/reset_pkg.sv
// Shared types and constants for the reset request generator.
// The cause encoding is what firmware reads back after a restart.
package reset_pkg;

    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        COOL   = 2'd1,
        IDLE   = 2'd2
    } rst_state_t;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_SW   = 2'b01;
    localparam logic [1:0] CAUSE_WDOG = 2'b10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_gen_if.sv
// Request/status bundle between reset sources and the reset generator.
interface reset_gen_if;
    import reset_pkg::*;

    logic       sw_rst_req;
    logic       wdog_en;
    logic       wdog_kick;
    logic       cause_clr;
    logic       sys_rst_n;
    logic [1:0] rst_cause;
    logic       busy;

    modport master (
        output sw_rst_req, wdog_en, wdog_kick, cause_clr,
        input  sys_rst_n, rst_cause, busy
    );

    modport slave (
        input  sw_rst_req, wdog_en, wdog_kick, cause_clr,
        output sys_rst_n, rst_cause, busy
    );

endinterface

// File: rtl/reset_gen_wdog_timer.sv
// Watchdog counter: counts unkicked enabled cycles and flags the last one.
// The count never wraps; it is cleared on kick, disable, clr, or at the timeout value.
module wdog_timer
    import reset_pkg::*;
#(
    parameter int WDOG_TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic kick,
    input  logic clr,
    output logic timeout
);

    localparam int WW = $clog2(WDOG_TIMEOUT);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_TIMEOUT - 1);

    logic [WW-1:0] cnt_r;
    logic [WW-1:0] cnt_nxt_s;
    logic          at_last_s;

    assign at_last_s = (cnt_r == WDOG_LAST);
    assign timeout   = at_last_s && en && !kick;

    // Next watchdog count.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr || kick || !en || at_last_s) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + WW'(1);
        end
    end

    // Watchdog count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/reset_gen.sv
// Raw system reset generator: power-on, software and watchdog sources,
// fixed-width low pulse, cooldown window and a readable last-cause register.
module reset_gen
    import reset_pkg::*;
#(
    parameter int HOLD_CYCLES  = 16,
    parameter int COOL_CYCLES  = 8,
    parameter int WDOG_TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    reset_gen_if.slave  bus
);

    localparam int CW = $clog2(max_int(HOLD_CYCLES, COOL_CYCLES));
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOL_CYCLES - 1);

    rst_state_t    state_r;
    rst_state_t    state_nxt_s;
    logic [CW-1:0] hold_cnt_r;
    logic [CW-1:0] hold_cnt_nxt_s;
    logic [1:0]    cause_r;
    logic [1:0]    cause_nxt_s;
    logic          sw_prev_r;
    logic          sys_rst_n_r;
    logic          sw_trig_s;
    logic          wd_trig_s;
    logic          trig_s;
    logic          wd_timeout_s;
    logic          wd_clr_s;

    assign sw_trig_s = (state_r == IDLE) && bus.sw_rst_req && !sw_prev_r;
    assign wd_trig_s = (state_r == IDLE) && wd_timeout_s;
    assign trig_s    = sw_trig_s || wd_trig_s;
    // Holding the watchdog at zero outside IDLE makes its period start at IDLE entry.
    assign wd_clr_s  = (state_r != IDLE) || trig_s;

    wdog_timer #(
        .WDOG_TIMEOUT (WDOG_TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (bus.wdog_en),
        .kick    (bus.wdog_kick),
        .clr     (wd_clr_s),
        .timeout (wd_timeout_s)
    );

    // Next-state, hold counter and cause selection.
    always_comb begin
        state_nxt_s    = state_r;
        hold_cnt_nxt_s = hold_cnt_r;
        cause_nxt_s    = cause_r;
        case (state_r)
            ASSERT: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_nxt_s    = COOL;
                    hold_cnt_nxt_s = '0;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + CW'(1);
                end
            end
            COOL: begin
                if (hold_cnt_r == COOL_LAST) begin
                    state_nxt_s    = IDLE;
                    hold_cnt_nxt_s = '0;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + CW'(1);
                end
            end
            IDLE: begin
                hold_cnt_nxt_s = '0;
                if (trig_s) begin
                    state_nxt_s = ASSERT;
                    cause_nxt_s = (sw_trig_s ? CAUSE_SW : CAUSE_POR) |
                                  (wd_trig_s ? CAUSE_WDOG : CAUSE_POR);
                end else if (bus.cause_clr) begin
                    cause_nxt_s = CAUSE_POR;
                end else begin
                    cause_nxt_s = cause_r;
                end
            end
            default: begin
                state_nxt_s    = ASSERT;
                hold_cnt_nxt_s = '0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ASSERT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counter, edge detect, cause and registered reset line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r  <= '0;
            sw_prev_r   <= 1'b1;
            cause_r     <= CAUSE_POR;
            sys_rst_n_r <= 1'b0;
        end else begin
            hold_cnt_r  <= hold_cnt_nxt_s;
            sw_prev_r   <= bus.sw_rst_req;
            cause_r     <= cause_nxt_s;
            sys_rst_n_r <= (state_nxt_s != ASSERT);
        end
    end

    assign bus.sys_rst_n = sys_rst_n_r;
    assign bus.rst_cause = cause_r;
    assign bus.busy      = (state_r != IDLE);

endmodule
